// File: rtl/sa_output_collector.sv
// Deskews staggered systolic-array column results, requantizes them to
// narrow signed lanes and buffers aligned vectors in a FWFT FIFO.
module sa_output_collector #(
  parameter int N_COLS     = 4,
  parameter int ACC_W      = 24,
  parameter int OUT_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic                      vec_valid_in,
  input  logic [N_COLS*ACC_W-1:0]   mac_in,
  input  logic [4:0]                shift,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N_COLS*OUT_W-1:0]   out_data,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                      overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic signed [ACC_W:0] SAT_HI =
    {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_LO =
    {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

  // One extra bit of headroom so the rounding add never wraps.
  function automatic logic [OUT_W-1:0] requant(
    input logic [ACC_W-1:0] v,
    input logic [4:0]       s
  );
    logic signed [ACC_W:0] w;
    logic signed [ACC_W:0] rnd;
    w   = $signed({v[ACC_W-1], v});
    rnd = '0;
    if (32'(s) >= ACC_W) begin
      w = {(ACC_W+1){v[ACC_W-1]}};
    end else begin
      if (s != 5'd0)
        rnd = (ACC_W+1)'(1) << (s - 5'd1);
      w = (w + rnd) >>> s;
    end
    if (w > SAT_HI)
      return SAT_HI[OUT_W-1:0];
    if (w < SAT_LO)
      return SAT_LO[OUT_W-1:0];
    return w[OUT_W-1:0];
  endfunction

  logic [ACC_W-1:0]        aligned [N_COLS];
  logic [N_COLS-1:0]       vpipe;
  logic [N_COLS*OUT_W-1:0] qvec;

  // Lane k arrives k cycles late, so it needs k fewer delay stages.
  for (genvar k = 0; k < N_COLS; k++) begin : g_lane
    localparam int L = N_COLS - k;
    logic [ACC_W-1:0] d [L];

    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
        for (int j = 0; j < L; j++)
          d[j] <= '0;
      end else begin
        d[0] <= mac_in[k*ACC_W +: ACC_W];
        for (int j = 1; j < L; j++)
          d[j] <= d[j-1];
      end
    end

    assign aligned[k] = d[L-1];
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)
      vpipe <= '0;
    else
      vpipe <= {vpipe[N_COLS-2:0], vec_valid_in};
  end

  always_comb begin
    qvec = '0;
    for (int k = 0; k < N_COLS; k++)
      qvec[k*OUT_W +: OUT_W] = requant(aligned[k], shift);
  end

  logic [N_COLS*OUT_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]           wptr;
  logic [AW-1:0]           rptr;
  logic [CW-1:0]           count;
  logic                    push_req;
  logic                    pop;
  logic                    full;
  logic                    do_push;

  assign push_req = vpipe[N_COLS-1];
  assign out_valid = (count != '0);
  assign pop      = out_valid && out_ready;
  assign full     = (count == CW'(FIFO_DEPTH));
  assign do_push  = push_req && (!full || pop);

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wptr] <= qvec;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push)
        wptr <= wptr + 1'b1;
      if (pop)
        rptr <= rptr + 1'b1;
      unique case (1'b1)
        do_push && !pop: count <= count + 1'b1;
        pop && !do_push: count <= count - 1'b1;
        default:         count <= count;
      endcase
      // The array cannot stall: a vector arriving at a full FIFO is lost.
      if (push_req && full && !pop)
        overflow <= 1'b1;
    end
  end

  assign out_data   = out_valid ? mem[rptr] : '0;
  assign fifo_count = count;

endmodule

// File: tb/tb_sa_output_collector.sv
// Scoreboard bench for sa_output_collector: staggered lane driver,
// expected vectors queued at drive time and checked on each pop.
module tb_sa_output_collector;

  localparam int N  = 4;
  localparam int AW = 24;
  localparam int OW = 8;

  logic            clk = 1'b0;
  logic            nrst;
  logic            vec_valid_in;
  logic [N*AW-1:0] mac_in;
  logic [4:0]      shift;
  logic            out_valid;
  logic            out_ready;
  logic [N*OW-1:0] out_data;
  logic [2:0]      fifo_count;
  logic            overflow;

  int n_cmp = 0;
  int n_err = 0;

  logic [N*OW-1:0] sb [$];
  logic [N*AW-1:0] hist [N];

  sa_output_collector #(
    .N_COLS(N), .ACC_W(AW), .OUT_W(OW), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .nrst(nrst),
    .vec_valid_in(vec_valid_in),
    .mac_in(mac_in),
    .shift(shift),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .fifo_count(fifo_count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [OW-1:0] q(input logic signed [AW-1:0] v,
                                      input int s);
    longint r;
    if (s >= AW) begin
      r = (v < 0) ? -1 : 0;
    end else begin
      r = longint'(v);
      if (s > 0)
        r = r + (longint'(1) << (s - 1));
      r = r >>> s;
    end
    if (r > 127)
      r = 127;
    if (r < -128)
      r = -128;
    return r[OW-1:0];
  endfunction

  function automatic logic [N*OW-1:0] expv(input logic [N*AW-1:0] v,
                                           input int s);
    logic [N*OW-1:0] o;
    o = '0;
    for (int k = 0; k < N; k++)
      o[k*OW +: OW] = q($signed(v[k*AW +: AW]), s);
    return o;
  endfunction

  function automatic logic [N*AW-1:0] pack(input int a, input int b,
                                           input int c, input int d);
    return {AW'(d), AW'(c), AW'(b), AW'(a)};
  endfunction

  function automatic logic [N*AW-1:0] rnd_vec();
    return {$urandom, $urandom, $urandom};
  endfunction

  // Lane k of the vector started k cycles ago goes out this cycle.
  task automatic drive(input logic vv, input logic [N*AW-1:0] vec);
    for (int j = N - 1; j > 0; j--)
      hist[j] = hist[j-1];
    hist[0] = vv ? vec : rnd_vec();
    for (int k = 0; k < N; k++)
      mac_in[k*AW +: AW] = hist[k][k*AW +: AW];
    vec_valid_in = vv;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    vec_valid_in = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
    sb.delete();
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    vec_valid_in = 1'b0;
    mac_in = '0;
    shift = '0;
    out_ready = 1'b0;
    for (int j = 0; j < N; j++)
      hist[j] = '0;
    #2;
    n_cmp += 4;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_valid: got %b want 0", out_valid);
    end
    if (out_data !== '0) begin
      n_err++;
      $display("FAIL reset_data: got %h want 0", out_data);
    end
    if (fifo_count !== 3'd0) begin
      n_err++;
      $display("FAIL reset_count: got %0d want 0", fifo_count);
    end
    if (overflow !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ovf: got %b want 0", overflow);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic test_basic();
    logic [N*OW-1:0] e;
    int pops;
    shift = 5'd0;
    out_ready = 1'b1;
    sb.push_back(32'h7F7FFD05);
    drive(1'b1, pack(5, -3, 127, 200));
    for (int i = 1; i <= 6; i++) begin
      drive(1'b0, '0);
      n_cmp++;
      if (out_valid !== (i == 4)) begin
        n_err++;
        $display("FAIL basic_valid_t%0d: got %b want %b",
                 i, out_valid, (i == 4));
      end
      if (out_valid && out_ready && sb.size() > 0) begin
        e = sb.pop_front();
        n_cmp++;
        if (out_data !== e) begin
          n_err++;
          $display("FAIL basic_data: got %h want %h", out_data, e);
        end
      end
    end
    sb.push_back(32'h807FFD05);
    drive(1'b1, pack(5, -3, 127, -200));
    pops = 0;
    for (int i = 1; i <= 6; i++) begin
      drive(1'b0, '0);
      if (out_valid && out_ready) begin
        pops++;
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL basic_neg_extra: got %h want none", out_data);
        end else begin
          e = sb.pop_front();
          if (out_data !== e) begin
            n_err++;
            $display("FAIL basic_neg: got %h want %h", out_data, e);
          end
        end
      end
    end
    n_cmp++;
    if (pops != 1) begin
      n_err++;
      $display("FAIL basic_neg_pops: got %0d want 1", pops);
    end
  endtask

  task automatic test_rounding();
    logic [N*OW-1:0] e;
    int pops;
    out_ready = 1'b1;
    for (int t = 0; t < 2; t++) begin
      shift = (t == 0) ? 5'd4 : 5'd31;
      if (t == 0) begin
        sb.push_back(32'h0100FF02);
        drive(1'b1, pack(24, -24, 7, 8));
      end else begin
        sb.push_back(32'h00FF00FF);
        drive(1'b1, pack(-5, 100, -1, 5));
      end
      pops = 0;
      for (int i = 0; i < 7; i++) begin
        if (out_valid && out_ready) begin
          pops++;
          n_cmp++;
          if (sb.size() == 0) begin
            n_err++;
            $display("FAIL round_extra: got %h want none", out_data);
          end else begin
            e = sb.pop_front();
            if (out_data !== e) begin
              n_err++;
              $display("FAIL round_s%0d: got %h want %h", shift, out_data, e);
            end
          end
        end
        drive(1'b0, '0);
      end
      n_cmp++;
      if (pops != 1) begin
        n_err++;
        $display("FAIL round_pops: got %0d want 1", pops);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [N*AW-1:0] v;
    logic [N*OW-1:0] e;
    int pops;
    shift = 5'd10;
    out_ready = 1'b1;
    pops = 0;
    for (int c = 0; c < 14; c++) begin
      if (out_valid && out_ready) begin
        pops++;
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL b2b_extra: got %h want none", out_data);
        end else begin
          e = sb.pop_front();
          if (out_data !== e) begin
            n_err++;
            $display("FAIL b2b_data%0d: got %h want %h", pops, out_data, e);
          end
        end
      end
      v = rnd_vec();
      if (c < 6)
        sb.push_back(expv(v, 10));
      drive(c < 6, v);
    end
    n_cmp += 2;
    if (pops != 6) begin
      n_err++;
      $display("FAIL b2b_pops: got %0d want 6", pops);
    end
    if (overflow !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_ovf: got %b want 0", overflow);
    end
  endtask

  task automatic test_overflow();
    logic [N*AW-1:0] v;
    logic [N*OW-1:0] e;
    logic [N*OW-1:0] head;
    int pops;
    do_reset();
    shift = 5'd0;
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      v = rnd_vec();
      if (i < 4)
        sb.push_back(expv(v, 0));
      drive(1'b1, v);
    end
    head = out_data;
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, '0);
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== head) begin
        n_err++;
        $display("FAIL ovf_stall%0d: got %b/%h want 1/%h",
                 i, out_valid, out_data, head);
      end
    end
    n_cmp += 2;
    if (fifo_count !== 3'd4) begin
      n_err++;
      $display("FAIL ovf_count: got %0d want 4", fifo_count);
    end
    if (overflow !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_flag: got %b want 1", overflow);
    end
    out_ready = 1'b1;
    pops = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid && out_ready) begin
        pops++;
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL ovf_extra: got %h want none", out_data);
        end else begin
          e = sb.pop_front();
          if (out_data !== e) begin
            n_err++;
            $display("FAIL ovf_drain%0d: got %h want %h", pops, out_data, e);
          end
        end
      end
      drive(1'b0, '0);
    end
    n_cmp += 3;
    if (pops != 4) begin
      n_err++;
      $display("FAIL ovf_pops: got %0d want 4", pops);
    end
    if (fifo_count !== 3'd0) begin
      n_err++;
      $display("FAIL ovf_empty: got %0d want 0", fifo_count);
    end
    if (overflow !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_sticky: got %b want 1", overflow);
    end
  endtask

  task automatic test_full_push_pop();
    logic [N*AW-1:0] v;
    logic [N*OW-1:0] e;
    int pops;
    do_reset();
    shift = 5'd3;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      v = rnd_vec();
      sb.push_back(expv(v, 3));
      drive(1'b1, v);
    end
    repeat (4) drive(1'b0, '0);
    n_cmp++;
    if (fifo_count !== 3'd4) begin
      n_err++;
      $display("FAIL fpp_fill: got %0d want 4", fifo_count);
    end
    v = rnd_vec();
    sb.push_back(expv(v, 3));
    drive(1'b1, v);
    repeat (3) drive(1'b0, '0);
    out_ready = 1'b1;
    e = sb.pop_front();
    n_cmp++;
    if (out_data !== e) begin
      n_err++;
      $display("FAIL fpp_head: got %h want %h", out_data, e);
    end
    drive(1'b0, '0);
    out_ready = 1'b0;
    n_cmp += 2;
    if (fifo_count !== 3'd4) begin
      n_err++;
      $display("FAIL fpp_count: got %0d want 4", fifo_count);
    end
    if (overflow !== 1'b0) begin
      n_err++;
      $display("FAIL fpp_ovf: got %b want 0", overflow);
    end
    out_ready = 1'b1;
    pops = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid && out_ready) begin
        pops++;
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL fpp_extra: got %h want none", out_data);
        end else begin
          e = sb.pop_front();
          if (out_data !== e) begin
            n_err++;
            $display("FAIL fpp_drain%0d: got %h want %h", pops, out_data, e);
          end
        end
      end
      drive(1'b0, '0);
    end
    n_cmp++;
    if (pops != 4) begin
      n_err++;
      $display("FAIL fpp_pops: got %0d want 4", pops);
    end
  endtask

  task automatic test_reset_inflight();
    logic [N*AW-1:0] v;
    logic [N*OW-1:0] e;
    int pops;
    do_reset();
    shift = 5'd0;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++)
      drive(1'b1, rnd_vec());
    repeat (4) drive(1'b0, '0);
    n_cmp++;
    if (fifo_count !== 3'd2) begin
      n_err++;
      $display("FAIL rif_fill: got %0d want 2", fifo_count);
    end
    for (int i = 0; i < 2; i++)
      drive(1'b1, rnd_vec());
    vec_valid_in = 1'b0;
    #2 nrst = 1'b0;
    #1;
    n_cmp += 2;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rif_valid: got %b want 0", out_valid);
    end
    if (fifo_count !== 3'd0) begin
      n_err++;
      $display("FAIL rif_count: got %0d want 0", fifo_count);
    end
    #1 nrst = 1'b1;
    sb.delete();
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, '0);
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL rif_ghost%0d: got %b want 0", i, out_valid);
      end
    end
    v = rnd_vec();
    sb.push_back(expv(v, 0));
    drive(1'b1, v);
    pops = 0;
    for (int i = 0; i < 7; i++) begin
      if (out_valid && out_ready) begin
        pops++;
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL rif_extra: got %h want none", out_data);
        end else begin
          e = sb.pop_front();
          if (out_data !== e) begin
            n_err++;
            $display("FAIL rif_data: got %h want %h", out_data, e);
          end
        end
      end
      drive(1'b0, '0);
    end
    n_cmp++;
    if (pops != 1) begin
      n_err++;
      $display("FAIL rif_pops: got %0d want 1", pops);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_back_to_back();
    test_overflow();
    test_full_push_pop();
    test_reset_inflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sa_output_collector.md
Name: sa_output_collector

Overview:
- Reads the accumulated `mac_out` results from the bottom row of an N-column systolic array of MAC PEs. In that array, column k produces its result k cycles after column 0.
- The block deskews the staggered column results into one aligned vector, requantizes each 24-bit signed sum to signed 8-bit, and buffers vectors in a small FIFO.
- It drains the FIFO over a valid/ready stream to the output writer.
- The array cannot stall, so a full FIFO drops vectors and raises a sticky overflow flag.

Parameters:
- N_COLS, 4, number of array columns; range 2..16.
- ACC_W, 24, width of each column accumulator input (signed).
- OUT_W, 8, width of each requantized output lane (signed).
- FIFO_DEPTH, 4, number of aligned output vectors buffered; power of two, ≥2.

Ports:
- clk  in  1  clock, rising edge.
- nrst  in  1  asynchronous active-low reset.
- vec_valid_in  in  1  high in the cycle column 0 presents a valid result; column k's result of the same vector is valid k cycles later.
- mac_in  in  N_COLS*ACC_W  column results; lane k is bits [k*ACC_W +: ACC_W].
- shift  in  5  arithmetic right-shift amount for requantization; static config, held stable while vectors are in flight.
- out_valid  out  1  FIFO head holds a vector.
- out_ready  in  1  consumer accepts the head vector.
- out_data  out  N_COLS*OUT_W  head vector; lane k is bits [k*OUT_W +: OUT_W].
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of vectors held.
- overflow  out  1  sticky: a vector was dropped because the FIFO was full.

Behaviour:
- Reset: asynchronous, active-low.
  - All registers clear immediately: delay lines, valid pipeline, FIFO pointers.
  - out_valid=0, out_data=0, fifo_count=0, overflow=0.
  - Vectors in flight are discarded; nothing after reset release is pushed until a fresh vec_valid_in.
- Edge naming: E0 is the edge that samples vec_valid_in=1. Ek is the k-th edge after E0.
- Deskew:
  - Lane k is sampled at Ek, then delayed through N_COLS-1-k registers.
  - vec_valid_in is delayed through N_COLS-1 registers.
  - All lanes and the delayed valid are aligned after E(N_COLS-1).
  - vec_valid_in may be high on consecutive cycles; every vector is deskewed independently.
- Requantization, per lane, on the aligned value v:
  - r = (v + (shift==0 ? 0 : 1<<(shift-1))) >>> shift: arithmetic shift, round half up.
  - Compute r in ACC_W+1 bits so the rounding add cannot wrap.
  - Saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - shift ≥ ACC_W yields 0 for v≥0 and -1 for v<0, before rounding.
- Push: the requantized vector is written into the FIFO at E(N_COLS) when the delayed valid is high.
  - Latency from E0 to out_valid is N_COLS cycles when the FIFO was empty and no pop occurs.
- FIFO: first-word-fall-through.
  - out_data is the head entry whenever out_valid=1; out_data is don't-care otherwise.
  - A pop occurs at an edge with out_valid && out_ready.
  - out_valid stays high until that pop.
  - out_data stays stable while out_valid=1 and out_ready=0.
- Boundary conditions:
  - Push while full with no pop in the same cycle: the vector is dropped, overflow is set and holds until reset, and FIFO contents are unchanged.
  - Push and pop in the same cycle while full: both occur, no drop, count unchanged.
  - Push and pop in the same cycle otherwise: both occur, count unchanged.
  - Pop while empty: ignored.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - fifo_count is always in the range 0..FIFO_DEPTH.

Test Plan:
- N_COLS=4, shift=0. One vector with lanes arriving staggered, values 5, -3, 127, 200; out_ready=1.
  - out_valid is high for exactly one cycle, 4 cycles after E0.
  - out_data lanes = 0x05, 0xFD, 0x7F, 0x7F (lane 3 saturates); lane 3 = -200 instead gives 0x80.
- Rounding:
  - shift=4, lane values 24, -24, 7, 8 → 0x02, 0xFF, 0x00, 0x01.
  - shift=31, lane value -5 → 0xFF.
- vec_valid_in high for 6 consecutive cycles with distinct values, out_ready=1 → 6 consecutive output vectors, in order, correctly aligned, overflow=0.
- out_ready=0, 6 vectors streamed with FIFO_DEPTH=4:
  - fifo_count reaches 4 and overflow=1.
  - Draining afterwards yields exactly the first 4 vectors.
  - out_data stays stable during the stall.
- FIFO full, out_ready=1 in the same cycle a new vector is pushed → no drop, overflow stays 0, fifo_count stays 4.
- Assert nrst=0 for one cycle, without a clock edge, while 2 vectors are in flight and 2 are buffered:
  - out_valid=0 and fifo_count=0 immediately.
  - No output appears until a new vec_valid_in.
